// File: rtl/gmsk_burst_sequencer.sv
// Burst framing for a GMSK modulator: lead tail, payload and trail tail bits,
// each presented as a one-cycle strobe once per symbol period.
module gmsk_burst_sequencer #(
  parameter int SAMPLES_PER_SYMBOL = 16,
  parameter int LEAD_BITS          = 3,
  parameter int PAYLOAD_BITS       = 142,
  parameter int TRAIL_BITS         = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic clk_en,
  input  logic burst_start,
  input  logic abort,
  input  logic bit_in,
  input  logic bit_valid,
  output logic bit_ready,
  output logic tx_bit,
  output logic tx_bit_strobe,
  output logic tx_active,
  output logic burst_done,
  output logic underrun
);

  localparam int SYM_W = (SAMPLES_PER_SYMBOL > 2) ? $clog2(SAMPLES_PER_SYMBOL) : 1;
  localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(SAMPLES_PER_SYMBOL - 1);
  localparam logic [9:0] LEAD_LAST  = 10'(LEAD_BITS - 1);
  localparam logic [9:0] PAY_LAST   = 10'(PAYLOAD_BITS - 1);
  localparam logic [9:0] TRAIL_LAST = 10'(TRAIL_BITS - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LEAD    = 3'd1;
  localparam logic [2:0] S_PAYLOAD = 3'd2;
  localparam logic [2:0] S_TRAIL   = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]       state;
  logic [2:0]       next_phase;
  logic [SYM_W-1:0] sym_cnt;
  logic [9:0]       bit_cnt;
  logic [9:0]       phase_last;
  logic             in_burst;
  logic             tick;

  assign in_burst  = (state == S_LEAD) || (state == S_PAYLOAD) || (state == S_TRAIL);
  assign tick      = in_burst && clk_en && (sym_cnt == SYM_LAST);
  assign bit_ready = !reset && (state == S_PAYLOAD) && tick;

  always_comb begin
    phase_last = TRAIL_LAST;
    next_phase = S_DONE;
    case (state)
      S_LEAD: begin
        phase_last = LEAD_LAST;
        next_phase = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        phase_last = PAY_LAST;
        next_phase = S_TRAIL;
      end
      default: begin
        phase_last = TRAIL_LAST;
        next_phase = S_DONE;
      end
    endcase
  end

  // Outputs are registered copies of the tick decisions, so the strobe and
  // its bit always land together one cycle after the symbol boundary.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= S_IDLE;
      sym_cnt       <= '0;
      bit_cnt       <= '0;
      tx_bit        <= 1'b0;
      tx_bit_strobe <= 1'b0;
      tx_active     <= 1'b0;
      burst_done    <= 1'b0;
      underrun      <= 1'b0;
    end else begin
      tx_bit_strobe <= tick;
      tx_active     <= in_burst;
      burst_done    <= (state == S_DONE);
      if (tick) begin
        tx_bit <= (state == S_PAYLOAD) && bit_valid && bit_in;
      end
      if (tick && (state == S_PAYLOAD) && !bit_valid) begin
        underrun <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          sym_cnt <= '0;
          bit_cnt <= '0;
          if (burst_start) begin
            state    <= S_LEAD;
            underrun <= 1'b0;
          end
        end
        S_DONE: begin
          state   <= S_IDLE;
          sym_cnt <= '0;
          bit_cnt <= '0;
        end
        default: begin
          // Abort restarts symbol timing so the trail tail gets full-length symbols.
          if (abort && (state != S_TRAIL)) begin
            state   <= S_TRAIL;
            sym_cnt <= '0;
            bit_cnt <= '0;
          end else begin
            if (clk_en) begin
              sym_cnt <= tick ? '0 : sym_cnt + SYM_W'(1);
            end
            if (tick) begin
              if (bit_cnt == phase_last) begin
                state   <= next_phase;
                bit_cnt <= '0;
              end else begin
                bit_cnt <= bit_cnt + 10'd1;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gmsk_burst_sequencer.sv
// Scoreboard bench for gmsk_burst_sequencer: expected strobe bits are queued
// at burst start and popped as the sequencer emits them.
module tb_gmsk_burst_sequencer;

  localparam int SPS    = 16;
  localparam int LEADB  = 3;
  localparam int PAYB   = 142;
  localparam int TRAILB = 3;
  localparam int TOTAL  = LEADB + PAYB + TRAILB;

  logic clock = 1'b0;
  logic reset, clk_en, burst_start, abort, bit_in, bit_valid;
  logic bit_ready, tx_bit, tx_bit_strobe, tx_active, burst_done, underrun;
  logic clk_en2, burst_start2, bit_in2;
  logic bit_ready2, tx_bit2, tx_bit_strobe2, tx_active2, burst_done2, underrun2;

  int n_checks = 0;
  int n_fail   = 0;
  bit exp_q[$];
  bit pay[0:1023];

  always #5 clock = ~clock;

  gmsk_burst_sequencer dut (
    .clock(clock), .reset(reset), .clk_en(clk_en), .burst_start(burst_start),
    .abort(abort), .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .tx_bit(tx_bit), .tx_bit_strobe(tx_bit_strobe), .tx_active(tx_active),
    .burst_done(burst_done), .underrun(underrun)
  );

  gmsk_burst_sequencer #(.SAMPLES_PER_SYMBOL(2)) dut_slow (
    .clock(clock), .reset(reset), .clk_en(clk_en2), .burst_start(burst_start2),
    .abort(1'b0), .bit_in(bit_in2), .bit_valid(1'b1), .bit_ready(bit_ready2),
    .tx_bit(tx_bit2), .tx_bit_strobe(tx_bit_strobe2), .tx_active(tx_active2),
    .burst_done(burst_done2), .underrun(underrun2)
  );

  // Starts a burst at the current negedge and follows it to burst_done (or reset).
  task automatic run_burst(input int invalid_slot, input int abort_slot, input int restart_at,
                           input int reset_slot, output int n_strobes, output int n_done);
    int c, k, prev, limit;
    bit stop, e;
    n_strobes = 0; n_done = 0; c = 0; k = 0; prev = 0; stop = 0;
    limit = (TOTAL + 4) * SPS;
    exp_q.delete();
    for (int i = 0; i < LEADB; i++) exp_q.push_back(1'b0);
    for (int i = 0; i < PAYB; i++) begin
      if (abort_slot >= 0 && i > abort_slot) break;
      if (reset_slot >= 0 && i >= reset_slot) break;
      exp_q.push_back((i == invalid_slot) ? 1'b0 : pay[i]);
    end
    if (reset_slot < 0) for (int i = 0; i < TRAILB; i++) exp_q.push_back(1'b0);
    burst_start = 1'b1; clk_en = 1'b1; bit_valid = 1'b1; abort = 1'b0;
    while (!stop) begin
      @(negedge clock);
      c++;
      burst_start = 1'b0; abort = 1'b0;
      if (c == 1) begin
        n_checks += 2;
        if (tx_active !== 1'b0) begin n_fail++; $display("[TB] FAIL active_entry: got %b want 0", tx_active); end
        if (underrun !== 1'b0) begin n_fail++; $display("[TB] FAIL underrun_clear: got %b want 0", underrun); end
      end
      if (c == 2) begin
        n_checks++;
        if (tx_active !== 1'b1) begin n_fail++; $display("[TB] FAIL active_on: got %b want 1", tx_active); end
      end
      if (tx_bit_strobe) begin
        n_strobes++;
        n_checks += 3;
        if (n_strobes == 1) begin
          if (c != 1 + SPS) begin n_fail++; $display("[TB] FAIL first_strobe: got cycle %0d want %0d", c, 1 + SPS); end
        end else if (c - prev != SPS) begin
          n_fail++; $display("[TB] FAIL spacing: got %0d want %0d (strobe %0d)", c - prev, SPS, n_strobes);
        end
        prev = c;
        if (tx_active !== 1'b1) begin n_fail++; $display("[TB] FAIL active_strobe: got %b want 1", tx_active); end
        if (exp_q.size() == 0) begin
          n_fail++; $display("[TB] FAIL extra_strobe: got strobe %0d, none expected", n_strobes);
        end else begin
          e = exp_q.pop_front();
          if (tx_bit !== e) begin n_fail++; $display("[TB] FAIL strobe_bit: got %b want %b (strobe %0d)", tx_bit, e, n_strobes); end
        end
      end
      if (burst_done) begin
        n_done++; stop = 1'b1;
        n_checks += 2;
        if (exp_q.size() != 0) begin n_fail++; $display("[TB] FAIL drained: got %0d left want 0", exp_q.size()); end
        if (tx_active !== 1'b0) begin n_fail++; $display("[TB] FAIL active_off: got %b want 0", tx_active); end
      end
      if (!stop) begin
        if (c == restart_at) burst_start = 1'b1;
        bit_in = pay[k];
        bit_valid = (k != invalid_slot);
        if (bit_ready) begin
          if (k == reset_slot) begin
            reset = 1'b1;
            #1;
            n_checks++;
            if (bit_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL ready_in_reset: got %b want 0", bit_ready); end
            @(negedge clock);
            n_checks++;
            if ({tx_bit, tx_bit_strobe, tx_active, burst_done, underrun} !== 5'b0) begin
              n_fail++; $display("[TB] FAIL reset_outputs: got %b want 00000",
                                 {tx_bit, tx_bit_strobe, tx_active, burst_done, underrun});
            end
            reset = 1'b0;
            stop = 1'b1;
          end else begin
            if (k == abort_slot) abort = 1'b1;
            k++;
          end
        end
      end
      if (c > limit) begin
        n_checks++; n_fail++; stop = 1'b1;
        $display("[TB] FAIL timeout: got %0d cycles without burst_done", c);
      end
    end
  endtask

  task automatic fill_payload(input bit random_bits);
    for (int i = 0; i < 1024; i++) pay[i] = random_bits ? 1'($urandom_range(0, 1)) : ((i % 2) == 0);
  endtask

  task automatic test_reset;
    reset = 1'b1; clk_en = 1'b1; burst_start = 1'b1; abort = 1'b0; bit_in = 1'b0; bit_valid = 1'b1;
    clk_en2 = 1'b0; burst_start2 = 1'b0; bit_in2 = 1'b0;
    repeat (3) @(negedge clock);
    n_checks += 2;
    if ({tx_bit, tx_bit_strobe, tx_active, burst_done, underrun} !== 5'b0) begin
      n_fail++; $display("[TB] FAIL reset_state: got %b want 00000", {tx_bit, tx_bit_strobe, tx_active, burst_done, underrun});
    end
    if (bit_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ready: got %b want 0", bit_ready); end
    reset = 1'b0; burst_start = 1'b0;
    repeat (4) @(negedge clock);
    n_checks++;
    if (tx_active !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_priority: got active %b want 0", tx_active); end
  endtask

  task automatic test_nominal;
    int ns, nd;
    fill_payload(1'b0);
    run_burst(-1, -1, -1, -1, ns, nd);
    n_checks += 3;
    if (ns != TOTAL) begin n_fail++; $display("[TB] FAIL nominal_count: got %0d want %0d", ns, TOTAL); end
    if (nd != 1) begin n_fail++; $display("[TB] FAIL nominal_done: got %0d want 1", nd); end
    if (underrun !== 1'b0) begin n_fail++; $display("[TB] FAIL nominal_underrun: got %b want 0", underrun); end
  endtask

  task automatic test_underrun;
    int ns, nd;
    fill_payload(1'b1);
    pay[10] = 1'b1;
    run_burst(10, -1, -1, -1, ns, nd);
    repeat (5) @(negedge clock);
    n_checks += 2;
    if (ns != TOTAL) begin n_fail++; $display("[TB] FAIL underrun_count: got %0d want %0d", ns, TOTAL); end
    if (underrun !== 1'b1) begin n_fail++; $display("[TB] FAIL underrun_sticky: got %b want 1", underrun); end
  endtask

  task automatic test_abort;
    int ns, nd;
    fill_payload(1'b0);
    run_burst(-1, 50, -1, -1, ns, nd);
    n_checks += 2;
    if (ns != LEADB + 51 + TRAILB) begin n_fail++; $display("[TB] FAIL abort_count: got %0d want %0d", ns, LEADB + 51 + TRAILB); end
    if (nd != 1) begin n_fail++; $display("[TB] FAIL abort_done: got %0d want 1", nd); end
  endtask

  task automatic test_restart_mid;
    int ns, nd;
    fill_payload(1'b1);
    run_burst(-1, -1, 100, -1, ns, nd);
    n_checks++;
    if (ns != TOTAL) begin n_fail++; $display("[TB] FAIL restart_count: got %0d want %0d", ns, TOTAL); end
  endtask

  task automatic test_back_to_back;
    int ns, nd;
    for (int b = 0; b < 2; b++) begin
      fill_payload(1'b1);
      run_burst(-1, -1, -1, -1, ns, nd);
      n_checks++;
      if (ns != TOTAL || nd != 1) begin
        n_fail++; $display("[TB] FAIL b2b_count: got %0d strobes/%0d done want %0d/1 (burst %0d)", ns, nd, TOTAL, b);
      end
    end
  endtask

  task automatic test_reset_mid;
    int ns, nd, seen;
    fill_payload(1'b1);
    run_burst(-1, -1, -1, 60, ns, nd);
    seen = 0;
    repeat (40) begin
      @(negedge clock);
      if (burst_done || tx_bit_strobe || tx_active) seen++;
    end
    n_checks += 3;
    if (ns != LEADB + 60) begin n_fail++; $display("[TB] FAIL reset_mid_count: got %0d want %0d", ns, LEADB + 60); end
    if (nd != 0 || seen != 0) begin n_fail++; $display("[TB] FAIL reset_mid_quiet: got %0d/%0d want 0/0", nd, seen); end
    if (exp_q.size() != 0) begin n_fail++; $display("[TB] FAIL reset_mid_drained: got %0d want 0", exp_q.size()); end
    run_burst(-1, -1, -1, -1, ns, nd);
    n_checks++;
    if (ns != TOTAL || nd != 1) begin n_fail++; $display("[TB] FAIL reset_mid_next: got %0d/%0d want %0d/1", ns, nd, TOTAL); end
  endtask

  task automatic test_abort_idle;
    int seen;
    seen = 0;
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    repeat (2 * SPS) begin
      @(negedge clock);
      if (tx_active || tx_bit_strobe || burst_done) seen++;
    end
    n_checks++;
    if (seen != 0) begin n_fail++; $display("[TB] FAIL abort_idle: got %0d active cycles want 0", seen); end
  endtask

  task automatic test_slow_enable;
    bit exp2[$];
    bit e;
    int c, k2, ns, prev;
    bit stop;
    for (int i = 0; i < LEADB; i++) exp2.push_back(1'b0);
    for (int i = 0; i < PAYB; i++) exp2.push_back((i % 2) == 0);
    for (int i = 0; i < TRAILB; i++) exp2.push_back(1'b0);
    c = 0; k2 = 0; ns = 0; prev = 0; stop = 0;
    burst_start2 = 1'b1; clk_en2 = 1'b1;
    while (!stop) begin
      @(negedge clock);
      c++;
      burst_start2 = 1'b0;
      if (tx_bit_strobe2) begin
        ns++;
        if (ns > 1) begin
          n_checks++;
          if (c - prev != 8) begin n_fail++; $display("[TB] FAIL slow_spacing: got %0d want 8 (strobe %0d)", c - prev, ns); end
        end
        prev = c;
        n_checks++;
        if (exp2.size() == 0) begin
          n_fail++; $display("[TB] FAIL slow_extra: got strobe %0d, none expected", ns);
        end else begin
          e = exp2.pop_front();
          if (tx_bit2 !== e) begin n_fail++; $display("[TB] FAIL slow_bit: got %b want %b (strobe %0d)", tx_bit2, e, ns); end
        end
      end
      if (burst_done2) stop = 1'b1;
      clk_en2 = ((c % 4) == 0);
      #1;
      bit_in2 = ((k2 % 2) == 0);
      if (bit_ready2) k2++;
      if (c > (TOTAL + 4) * 8) begin
        n_checks++; n_fail++; stop = 1'b1;
        $display("[TB] FAIL slow_timeout: got %0d cycles without burst_done", c);
      end
    end
    clk_en2 = 1'b0;
    n_checks++;
    if (ns != TOTAL) begin n_fail++; $display("[TB] FAIL slow_count: got %0d want %0d", ns, TOTAL); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_underrun();
    test_abort();
    test_restart_mid();
    test_back_to_back();
    test_reset_mid();
    test_abort_idle();
    test_slow_enable();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
